// File: rtl/joy_map.sv
// Joystick-to-Spectrum mapping: debounces both joystick words and presents them as a
// Kempston port or as Sinclair/Cursor key presses. Optional autofire: JOY_AUTOFIRE_EN.
module joy_map #(
    parameter int DIV      = 3500,
    parameter int AF_TICKS = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  joy1,
    input  logic [7:0]  joy2,
    input  logic [1:0]  mode,
    input  logic [1:0]  afire,
    input  logic [15:0] a,
    input  logic        iorq,
    input  logic        rd,
    output logic [7:0]  q,
    output logic        qe,
    output logic [4:0]  krow
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] MODE_KEMPSTON = 2'b00;
    localparam logic [1:0] MODE_SINCLAIR = 2'b01;
    localparam logic [1:0] MODE_CURSOR   = 2'b10;

    // Direction/fire bit positions inside a joystick word.
    localparam int J_RIGHT = 0;
    localparam int J_LEFT  = 1;
    localparam int J_DOWN  = 2;
    localparam int J_UP    = 3;
    localparam int J_FIRE1 = 4;

    // ------------------------------------------------------------------
    // Debounce tick generator
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Line debounce: joy1 lines in [5:0], joy2 lines in [11:6]
    // ------------------------------------------------------------------
    logic [11:0]      raw;
    logic [11:0]      filt_q, filt_d;
    logic [11:0][1:0] dcnt_q, dcnt_d;

    assign raw = {joy2[5:0], joy1[5:0]};

    always_comb begin
        filt_d = filt_q;
        dcnt_d = dcnt_q;
        if (tick) begin
            for (int i = 0; i < 12; i++) begin
                if (raw[i] != filt_q[i]) begin
                    // Third consecutive disagreeing tick accepts the new level.
                    if (dcnt_q[i] == 2'd2) begin
                        filt_d[i] = raw[i];
                        dcnt_d[i] = 2'd0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 2'd1;
                    end
                end else begin
                    dcnt_d[i] = 2'd0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filt_q <= '0;
            dcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            dcnt_q <= dcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Autofire gate on fire1 (per joystick)
    // ------------------------------------------------------------------
    logic [1:0] fire_gate;

`ifdef JOY_AUTOFIRE_EN
    localparam int AW = (AF_TICKS > 1) ? $clog2(AF_TICKS) : 1;

    logic [AW-1:0] af_cnt_q, af_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        af_cnt_d = af_cnt_q;
        phase_d  = phase_q;
        if (tick) begin
            if (af_cnt_q == AW'(AF_TICKS - 1)) begin
                af_cnt_d = '0;
                phase_d  = ~phase_q;
            end else begin
                af_cnt_d = af_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            af_cnt_q <= '0;
            phase_q  <= 1'b0;
        end else begin
            af_cnt_q <= af_cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign fire_gate = ~afire | {2{phase_q}};
`else
    logic unused_afire;
    assign unused_afire = ^afire;
    assign fire_gate    = 2'b11;
`endif

    logic [5:0] f1, f2;

    always_comb begin
        f1 = filt_q[5:0];
        f2 = filt_q[11:6];
        f1[J_FIRE1] = filt_q[J_FIRE1] & fire_gate[0];
        f2[J_FIRE1] = filt_q[6 + J_FIRE1] & fire_gate[1];
    end

    // ------------------------------------------------------------------
    // Kempston port: capture on the first clock of an access, hold until it ends
    // ------------------------------------------------------------------
    logic       acc;
    logic       acc_q, acc_d;
    logic [7:0] q_q, q_d;
    logic       qe_q, qe_d;

    assign acc = iorq & rd & ~a[5];

    always_comb begin
        acc_d = acc;
        q_d   = q_q;
        qe_d  = qe_q;
        if ((mode != MODE_KEMPSTON) || !acc) begin
            q_d  = 8'h00;
            qe_d = 1'b0;
        end else if (!acc_q) begin
            q_d  = {2'b00, f1};
            qe_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= 1'b0;
            q_q   <= 8'h00;
            qe_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            qe_q  <= qe_d;
        end
    end

    assign q  = q_q;
    assign qe = qe_q;

    // ------------------------------------------------------------------
    // Keyboard half-row contributions (active-high presses, inverted at the end)
    // ------------------------------------------------------------------
    function automatic logic [4:0] sinclair1(input logic [5:0] j);
        logic [4:0] k;
        k    = 5'h00;
        k[4] = j[J_LEFT];
        k[3] = j[J_RIGHT];
        k[2] = j[J_DOWN];
        k[1] = j[J_UP];
        k[0] = j[J_FIRE1];
        return k;
    endfunction

    function automatic logic [4:0] sinclair2(input logic [5:0] j);
        logic [4:0] k;
        k    = 5'h00;
        k[0] = j[J_LEFT];
        k[1] = j[J_RIGHT];
        k[2] = j[J_DOWN];
        k[3] = j[J_UP];
        k[4] = j[J_FIRE1];
        return k;
    endfunction

    logic [4:0] press_effe, press_f7fe;
    logic [4:0] row_effe, row_f7fe;

    always_comb begin
        press_effe = 5'h00;
        press_f7fe = 5'h00;
        case (mode)
            MODE_KEMPSTON: begin
                press_effe = sinclair1(f2);
            end
            MODE_SINCLAIR: begin
                press_effe = sinclair1(f1);
                press_f7fe = sinclair2(f2);
            end
            MODE_CURSOR: begin
                press_f7fe[4] = f1[J_LEFT];
                press_effe[4] = f1[J_DOWN];
                press_effe[3] = f1[J_UP];
                press_effe[2] = f1[J_RIGHT];
                press_effe[0] = f1[J_FIRE1];
            end
            default: begin
                press_effe = 5'h00;
                press_f7fe = 5'h00;
            end
        endcase
    end

    // Both half-rows may be addressed at once; their active-low keys combine by AND.
    assign row_effe = a[12] ? 5'h1F : ~press_effe;
    assign row_f7fe = a[11] ? 5'h1F : ~press_f7fe;
    assign krow     = row_effe & row_f7fe;

    logic unused_bits;
    assign unused_bits = ^{joy1[7:6], joy2[7:6], a[15:13], a[10:6], a[4:0]};

endmodule
